// File: rtl/aes_iter_encrypt_ctrl.sv
// Iterative AES-128 encryptor: one round per clock over a shared round datapath,
// with valid/ready block capture, abort, and a held result until the sink takes it.
module aes_iter_encrypt_ctrl #(
    parameter int N  = 128,
    parameter int Nr = 10,
    parameter int Nk = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [N-1:0] in_key,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [3:0]   round_idx
);
    localparam int KW = 128 * (Nr + 1);
    localparam int NW = 4 * (Nr + 1);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq, inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   b0, b1, b2, b3;
        for (int c = 0; c < 4; c++) begin
            b0 = s[127-32*c -: 8];
            b1 = s[119-32*c -: 8];
            b2 = s[111-32*c -: 8];
            b3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
            o[119-32*c -: 8] = b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3;
            o[111-32*c -: 8] = b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3;
            o[103-32*c -: 8] = xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3);
        end
        return o;
    endfunction

    function automatic logic [KW-1:0] key_expansion(input logic [N-1:0] key);
        logic [NW-1:0][31:0] w;
        logic [31:0]         t;
        logic [7:0]          rcon;
        logic [KW-1:0]       fk;
        rcon = 8'h01;
        for (int i = 0; i < Nk; i++) w[i] = key[N-1-32*i -: 32];
        for (int i = Nk; i < NW; i++) begin
            t = w[i-1];
            if (i % Nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
                rcon = xtime(rcon);
            end else if (Nk > 6 && i % Nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-Nk] ^ t;
        end
        for (int i = 0; i < NW; i++) fk[KW-1-32*i -: 32] = w[i];
        return fk;
    endfunction

    fsm_t           fsm_q, fsm_d;
    logic [127:0]   state_q;
    logic [N-1:0]   key_q;
    logic [3:0]     round_q;
    logic [N-1:0]   kexp_key;
    logic [KW-1:0]  fullkeys;
    logic [127:0]   rk [0:Nr];
    logic [3:0]     rk_sel;
    logic [127:0]   rk_cur, sb, sr, mc;
    logic           accept;

    // Round-key selection and the single shared round datapath.
    always_comb begin
        kexp_key = (fsm_q == IDLE) ? in_key : key_q;
        fullkeys = key_expansion(kexp_key);
        for (int r = 0; r <= Nr; r++) rk[r] = fullkeys[KW-1-128*r -: 128];
        rk_sel = (fsm_q == IDLE) ? 4'd0 : (fsm_q == FINAL) ? 4'(Nr) : round_q;
        rk_cur = rk[rk_sel];
        sb     = sub_bytes(state_q);
        sr     = shift_rows(sb);
        mc     = mix_columns(sr);
        accept = (fsm_q == IDLE) && in_valid && !abort;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_q <= IDLE;
        else        fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:  if (accept) fsm_d = ROUND;
            ROUND: if (abort) fsm_d = IDLE;
                   else if (round_q == 4'(Nr - 1)) fsm_d = FINAL;
            FINAL: fsm_d = abort ? IDLE : DONE;
            DONE:  if (abort || out_ready) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            key_q   <= '0;
            round_q <= '0;
        end else if (abort && fsm_q != IDLE) begin
            state_q <= '0;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            case (fsm_q)
                IDLE: if (accept) begin
                    state_q <= in_data ^ rk_cur;
                    key_q   <= in_key;
                    round_q <= 4'd1;
                end
                ROUND: begin
                    state_q <= mc ^ rk_cur;
                    round_q <= round_q + 4'd1;
                end
                FINAL: begin
                    state_q <= sr ^ rk_cur;
                    round_q <= 4'd0;
                end
                DONE: if (out_ready) state_q <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = (fsm_q == IDLE);
        out_valid = (fsm_q == DONE);
        out_data  = (fsm_q == DONE) ? state_q : 128'd0;
        busy      = (fsm_q == ROUND) || (fsm_q == FINAL);
        round_idx = (fsm_q == ROUND) ? round_q : (fsm_q == FINAL) ? 4'(Nr) : 4'd0;
    end

endmodule

// File: tb/tb_aes_iter_encrypt_ctrl.sv
// Directed bench for aes_iter_encrypt_ctrl using FIPS-197 known-answer vectors.
module tb_aes_iter_encrypt_ctrl;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic [3:0]   round_idx;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_iter_encrypt_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_key(in_key), .abort(abort), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy), .round_idx(round_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d, input logic [127:0] k);
        in_valid = 1'b1;
        in_data  = d;
        in_key   = k;
        step();
        in_valid = 1'b0;
        in_data  = ~d;
        in_key   = ~k;
    endtask

    // Called just after the accept edge; ends just after the edge that raises out_valid.
    task automatic run_rounds(input logic [127:0] want_ct, input string tag);
        chk({tag, "_ridx_first"}, round_idx, 1);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_in_ready_low"}, in_ready, 0);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("%s_ridx_%0d", tag, k + 1), round_idx, k + 1);
            chk($sformatf("%s_noval_%0d", tag, k), out_valid, 0);
        end
        step();
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_out_data"}, out_data, want_ct);
        chk({tag, "_ridx_done"}, round_idx, 0);
        chk({tag, "_busy_done"}, busy, 0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ridx"}, round_idx, 0);
    endtask

    initial begin
        logic seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        #3;
        check_idle("reset");
        step();
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Vector 1 with the sink always ready.
        send(PT1, K1);
        run_rounds(CT1, "v1");
        step();
        check_idle("v1_after");

        // Vector 2 with the sink stalling for five cycles.
        out_ready = 1'b0;
        send(PT2, K2);
        run_rounds(CT2, "v2");
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("stall_valid_%0d", i), out_valid, 1);
            chk($sformatf("stall_data_%0d", i), out_data, CT2);
            chk($sformatf("stall_in_ready_%0d", i), in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        chk("stall_release_in_ready", in_ready, 1);
        chk("stall_release_valid", out_valid, 0);

        // Back-to-back: in_valid held high, inputs changed mid-block.
        in_valid = 1'b1;
        in_data  = PT1;
        in_key   = K1;
        step();
        in_data = PT2;
        in_key  = K2;
        run_rounds(CT1, "b2b_a");
        step();
        chk("b2b_gap_in_ready", in_ready, 1);
        chk("b2b_gap_busy", busy, 0);
        step();
        in_valid = 1'b0;
        in_data  = 128'hdeadbeef_00000000_cafef00d_12345678;
        in_key   = 128'hffffffff_00000000_ffffffff_00000000;
        run_rounds(CT2, "b2b_b");
        step();
        check_idle("b2b_after");

        // Abort at round 5, then abort-versus-accept priority in IDLE.
        send(PT2, K2);
        for (int i = 0; i < 4; i++) step();
        chk("abort_at_ridx", round_idx, 5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("abort_after");
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_output", seen, 0);
        in_valid = 1'b1;
        in_data  = PT1;
        in_key   = K1;
        abort    = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_idle_no_accept_busy", busy, 0);
        chk("abort_idle_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        run_rounds(CT1, "post_abort");
        step();
        check_idle("post_abort_after");

        // Asynchronous reset in the middle of round 3.
        send(PT1, K1);
        step();
        step();
        chk("rst_at_ridx", round_idx, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        step();
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid || busy) seen = 1'b1;
        end
        chk("rst_no_output", seen, 0);
        send(PT2, K2);
        run_rounds(CT2, "post_rst");
        step();
        check_idle("post_rst_after");

        // Abort and out_ready together in DONE.
        send(PT1, K1);
        run_rounds(CT1, "abort_done");
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("abort_done_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
